sync_ram: RTL and testbench
===========================

# sync_ram

Parametrised synchronous single-port RAM for the memory subsystem: the clocked, width/depth-generic successor to the team's asynchronous RAM model. It adds a registered read with a valid strobe, an automatic post-reset clear sweep with a busy flag, and an out-of-range address error. It sits behind the bus front-end wherever a small scratch memory is needed.

## Interface
- `ADDR_WIDTH`, default 10: address bus width.
- `DATA_WIDTH`, default 8: word width.
- `DEPTH`, default 1024: number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- `INIT_VALUE`, default 0: word written to every location by the clear sweep.

Ports:
- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cs` in 1: chip select; a request is accepted only when cs=1 and busy=0.
- `wr` in 1: with cs, 1 = write and 0 = read.
- `addr` in ADDR_WIDTH: word address.
- `data_in` in DATA_WIDTH: write data.
- `data_out` out DATA_WIDTH: registered read data.
- `rd_valid` out 1: one-cycle pulse when data_out carries a new read result.
- `busy` out 1: clear sweep in progress; requests are ignored while it is high.
- `addr_err` out 1: one-cycle pulse for an accepted request with addr ≥ DEPTH.

## Operation
- States: CLEAR and READY.
- Reset (rst_n=0) forces CLEAR with clr_ptr=0, data_out=0, rd_valid=0, addr_err=0, busy=1. The array itself has no reset.
- CLEAR:
  - Each cycle, mem[clr_ptr] ← INIT_VALUE and clr_ptr increments.
  - On the cycle that writes location DEPTH-1, the next state is READY and busy falls.
  - The sweep takes exactly DEPTH cycles after rst_n deasserts.
  - cs, wr, addr and data_in are ignored in CLEAR: no write, no rd_valid, no addr_err.
- READY, request accepted (cs=1):
  - wr=1 and addr<DEPTH: mem[addr] ← data_in. data_out holds its value and rd_valid=0.
  - wr=0 and addr<DEPTH: data_out ← mem[addr] on the next edge and rd_valid=1 for that cycle.
  - addr ≥ DEPTH: no array access, data_out unchanged, rd_valid=0, addr_err=1 for one cycle. This applies to both reads and writes.
- READY, cs=0: no access; rd_valid=0 and addr_err=0. data_out holds its last value.
- Width rules:
  - clr_ptr is ADDR_WIDTH bits wide.
  - The DEPTH-1 terminal compare is done at ADDR_WIDTH+1 bits so that DEPTH=2**ADDR_WIDTH does not wrap early.
  - addr_err logic is constant-0 when DEPTH=2**ADDR_WIDTH.
- Back-to-back:
  - One request is accepted per cycle with no bubbles.
  - A read of an address written in the previous cycle returns the new data.
- Reset mid-operation:
  - Any rst_n assertion, including during CLEAR, restarts the sweep from address 0.
  - A read in flight is discarded, so rd_valid stays 0.

## Timing
- Read latency: 1 cycle. A request at edge N produces data_out and rd_valid valid after edge N+1.
- Write latency: data is visible to a read issued on the following cycle.
- busy deasserts after DEPTH rising edges following rst_n release. The first request can be accepted on the edge where busy is sampled 0.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `sync_ram_pkg`: state enum `ram_state_t` {ST_CLEAR, ST_READY}, plus a function `clog2_depth` used for the compare width.
- Sub-module `sync_ram_array`: a plain clocked storage array with one write port (we, waddr, wdata) and one registered read port. It contains no reset and no control logic.
- The top level contains the FSM, clear pointer, request decode, range check and output registers. A write-port mux selects between the sweep and the user path.

## Test plan
- Reset release with DEPTH=1024 → busy=1 for exactly 1024 cycles, then 0. Reads of addresses 0, 511 and 1023 all return 0 with rd_valid pulsing one cycle later.
- Write (k+k)%254 to every k in 0..1023, then read all of them back → each data_out matches, with one rd_valid pulse per read and no gaps.
- Write 0x5A to address 7 in cycle N, read address 7 in cycle N+1 → data_out=0x5A after edge N+2.
- DEPTH=1000, ADDR_WIDTH=10: write to 1000, then read 1023 → addr_err pulses each time, rd_valid=0, data_out unchanged, and location 999 is intact.
- cs=1, wr=1 to address 3 during CLEAR → ignored, and address 3 reads INIT_VALUE after busy falls.
- Assert rst_n for one cycle at sweep cycle 500 → busy stays high for 1024 further cycles and all locations read INIT_VALUE.

Source files
------------

// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the synchronous scratch RAM.
package sync_ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } ram_state_t;

   // Number of bits needed to hold the value 'depth' itself (not depth-1).
   function automatic int clog2_depth(input int depth);
      int bits;
      bits = 0;
      for (int b = 0; b < 31; b++) begin
         if ((1 << b) <= depth) bits = b + 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/sync_ram_array.sv
// Plain storage array: one write port and one enabled, registered read port.
module sync_ram_array
   import sync_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 1024
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
      if (re) r_rdata <= r_mem[raddr];
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/sync_ram.sv
// Synchronous single-port RAM with post-reset clear sweep, registered read
// with valid strobe, and out-of-range address error.
module sync_ram
   import sync_ram_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    DEPTH      = 1024,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic                  wr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  busy,
   output logic                  addr_err,
   output logic                  dbg_ready
);

   // One extra bit so that DEPTH = 2**ADDR_WIDTH does not alias to zero.
   localparam int CMP_W = (clog2_depth(DEPTH) > ADDR_WIDTH) ? clog2_depth(DEPTH) : ADDR_WIDTH + 1;
   localparam logic [CMP_W-1:0] LAST_IDX   = CMP_W'(DEPTH - 1);
   localparam logic [CMP_W-1:0] DEPTH_C    = CMP_W'(DEPTH);
   localparam bit               FULL_RANGE = (DEPTH == (1 << ADDR_WIDTH));

   ram_state_t            r_state;
   logic [ADDR_WIDTH-1:0] r_clr_ptr;
   logic                  r_busy;
   logic                  r_rd_valid;
   logic                  r_addr_err;
   logic                  r_have_rd;

   logic                  w_in_range;
   logic                  w_accept;
   logic                  w_re;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_rdata;

   generate
      if (FULL_RANGE) begin : g_full
         assign w_in_range = 1'b1;
      end else begin : g_partial
         assign w_in_range = ({1'b0, addr} < DEPTH_C);
      end
   endgenerate

   assign w_accept = (r_state == ST_READY) && cs;
   assign w_re     = w_accept && !wr && w_in_range;
   assign w_we     = (r_state == ST_CLEAR) || (w_accept && wr && w_in_range);
   assign w_waddr  = (r_state == ST_CLEAR) ? r_clr_ptr : addr;
   assign w_wdata  = (r_state == ST_CLEAR) ? INIT_VALUE : data_in;

   sync_ram_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (w_we),
      .waddr (w_waddr),
      .wdata (w_wdata),
      .re    (w_re),
      .raddr (addr),
      .rdata (w_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_CLEAR;
         r_clr_ptr  <= '0;
         r_busy     <= 1'b1;
         r_rd_valid <= 1'b0;
         r_addr_err <= 1'b0;
         r_have_rd  <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_rd_valid <= 1'b0;
               r_addr_err <= 1'b0;
               if ({1'b0, r_clr_ptr} == LAST_IDX) begin
                  r_state   <= ST_READY;
                  r_busy    <= 1'b0;
                  r_clr_ptr <= '0;
               end else begin
                  r_clr_ptr <= r_clr_ptr + 1'b1;
               end
            end
            default: begin
               r_rd_valid <= w_re;
               r_addr_err <= w_accept && !w_in_range;
               if (w_re) r_have_rd <= 1'b1;
            end
         endcase
      end
   end

   // The array read register has no reset; mask it until the first read after reset.
   assign data_out  = r_have_rd ? w_rdata : '0;
   assign rd_valid  = r_rd_valid;
   assign busy      = r_busy;
   assign addr_err  = r_addr_err;
   assign dbg_ready = (r_state == ST_READY);

endmodule

// File: tb/tb_sync_ram.sv
// Directed self-checking bench for sync_ram: a full-range instance (DEPTH=1024)
// and a partial-range instance (DEPTH=1000, INIT_VALUE=0xA5).
module tb_sync_ram;

   logic       clk;
   logic       rst_n, cs, wr;
   logic [9:0] addr;
   logic [7:0] data_in, data_out;
   logic       rd_valid, busy, addr_err, dbg_ready;

   logic       s_rst_n, s_cs, s_wr;
   logic [9:0] s_addr;
   logic [7:0] s_data_in, s_data_out;
   logic       s_rd_valid, s_busy, s_addr_err, s_dbg_ready;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   sync_ram #(
      .ADDR_WIDTH (10), .DATA_WIDTH (8), .DEPTH (1024), .INIT_VALUE (8'h00)
   ) u_dut (
      .clk (clk), .rst_n (rst_n), .cs (cs), .wr (wr), .addr (addr),
      .data_in (data_in), .data_out (data_out), .rd_valid (rd_valid),
      .busy (busy), .addr_err (addr_err), .dbg_ready (dbg_ready)
   );

   sync_ram #(
      .ADDR_WIDTH (10), .DATA_WIDTH (8), .DEPTH (1000), .INIT_VALUE (8'hA5)
   ) u_dut_s (
      .clk (clk), .rst_n (s_rst_n), .cs (s_cs), .wr (s_wr), .addr (s_addr),
      .data_in (s_data_in), .data_out (s_data_out), .rd_valid (s_rd_valid),
      .busy (s_busy), .addr_err (s_addr_err), .dbg_ready (s_dbg_ready)
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- drivers ----------------
   // Called at a negedge; drives one request and returns at the next negedge,
   // by which time the outputs reflect that request.
   task automatic step(input bit sel, input logic c, input logic w,
                       input logic [9:0] a, input logic [7:0] d);
      if (sel) begin
         s_cs = c; s_wr = w; s_addr = a; s_data_in = d; cs = 1'b0;
      end else begin
         cs = c; wr = w; addr = a; data_in = d; s_cs = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      cs = 1'b0; s_cs = 1'b0;
   endtask

   // Counts rising edges until busy falls on the main instance.
   task automatic count_busy(output int cnt);
      int guard;
      logic b0;
      cnt = 0;
      guard = 0;
      while (busy && guard < 3000) begin
         b0 = busy;
         @(negedge clk);
         guard++;
         if (b0) cnt++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int cnt, s_cnt, guard;
      logic spur, b0, sb0;
      logic [7:0] e;

      rst_n = 1'b0; s_rst_n = 1'b0;
      cs = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
      s_cs = 1'b0; s_wr = 1'b0; s_addr = '0; s_data_in = '0;
      repeat (3) @(negedge clk);

      check("rst_busy",     32'(busy), 32'd1);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_addr_err", 32'(addr_err), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_s_busy",   32'(s_busy), 32'd1);

      // Release both; write attempts to address 3 during the sweep must be ignored.
      rst_n = 1'b1; s_rst_n = 1'b1;
      cs = 1'b1; wr = 1'b1; addr = 10'd3; data_in = 8'h77;
      cnt = 0; s_cnt = 0; guard = 0; spur = 1'b0;
      while ((busy || s_busy) && guard < 3000) begin
         b0 = busy; sb0 = s_busy;
         @(negedge clk);
         guard++;
         if (b0) cnt++;
         if (sb0) s_cnt++;
         if (b0 && (rd_valid || addr_err)) spur = 1'b1;
         if (b0 && !busy) cs = 1'b0;
      end
      idle();
      check("clear_cycles",   32'(cnt), 32'd1024);
      check("s_clear_cycles", 32'(s_cnt), 32'd1000);
      check("clear_quiet",    32'(spur), 32'd0);

      // Post-clear reads.
      step(0, 1'b1, 1'b0, 10'd0, 8'h00);
      check("rd0_valid", 32'(rd_valid), 32'd1);
      check("rd0_data",  32'(data_out), 32'h00);
      step(0, 1'b1, 1'b0, 10'd511, 8'h00);
      check("rd511_valid", 32'(rd_valid), 32'd1);
      check("rd511_data",  32'(data_out), 32'h00);
      step(0, 1'b1, 1'b0, 10'd1023, 8'h00);
      check("rd1023_valid", 32'(rd_valid), 32'd1);
      check("rd1023_data",  32'(data_out), 32'h00);
      check("rd1023_noerr", 32'(addr_err), 32'd0);
      step(0, 1'b1, 1'b0, 10'd3, 8'h00);
      check("clr_wr_ignored", 32'(data_out), 32'h00);

      // Fill every location with (k+k)%254, then read back-to-back.
      for (int k = 0; k < 1024; k++) begin
         e = 8'((k + k) % 254);
         step(0, 1'b1, 1'b1, 10'(k), e);
         exp_q.push_back(e);
      end
      check("wr_no_valid", 32'(rd_valid), 32'd0);
      check("wr_hold",     32'(data_out), 32'h00);
      for (int k = 0; k < 1024; k++) begin
         step(0, 1'b1, 1'b0, 10'(k), 8'h00);
         e = exp_q.pop_front();
         check($sformatf("rb_valid[%0d]", k), 32'(rd_valid), 32'd1);
         check($sformatf("rb_data[%0d]", k),  32'(data_out), 32'(e));
      end

      // Write then read the same address on the next cycle; last readback was 2046%254 = 0x0E.
      step(0, 1'b1, 1'b1, 10'd7, 8'h5A);
      check("raw_wr_valid", 32'(rd_valid), 32'd0);
      check("raw_wr_hold",  32'(data_out), 32'h0E);
      step(0, 1'b1, 1'b0, 10'd7, 8'h00);
      check("raw_rd_valid", 32'(rd_valid), 32'd1);
      check("raw_rd_data",  32'(data_out), 32'h5A);
      step(0, 1'b0, 1'b0, 10'd7, 8'h00);
      check("cs0_valid", 32'(rd_valid), 32'd0);
      check("cs0_hold",  32'(data_out), 32'h5A);

      // Partial-range instance: INIT value and out-of-range handling.
      step(1, 1'b1, 1'b0, 10'd999, 8'h00);
      check("s_rd999_valid", 32'(s_rd_valid), 32'd1);
      check("s_rd999_init",  32'(s_data_out), 32'hA5);
      step(1, 1'b1, 1'b0, 10'd0, 8'h00);
      check("s_rd0_init", 32'(s_data_out), 32'hA5);
      step(1, 1'b1, 1'b1, 10'd999, 8'h3C);
      check("s_wr999_err", 32'(s_addr_err), 32'd0);
      step(1, 1'b1, 1'b1, 10'd1000, 8'h55);
      check("s_wr1000_err",   32'(s_addr_err), 32'd1);
      check("s_wr1000_valid", 32'(s_rd_valid), 32'd0);
      check("s_wr1000_hold",  32'(s_data_out), 32'hA5);
      step(1, 1'b1, 1'b0, 10'd1023, 8'h00);
      check("s_rd1023_err",   32'(s_addr_err), 32'd1);
      check("s_rd1023_valid", 32'(s_rd_valid), 32'd0);
      check("s_rd1023_hold",  32'(s_data_out), 32'hA5);
      step(1, 1'b1, 1'b0, 10'd999, 8'h00);
      check("s_rd999_err",   32'(s_addr_err), 32'd0);
      check("s_rd999_valid", 32'(s_rd_valid), 32'd1);
      check("s_rd999_data",  32'(s_data_out), 32'h3C);
      step(1, 1'b0, 1'b0, 10'd0, 8'h00);
      check("s_idle_err", 32'(s_addr_err), 32'd0);

      // Reset lands between a read request and its clock edge: the read is discarded.
      cs = 1'b1; wr = 1'b0; addr = 10'd7;
      #2 rst_n = 1'b0;
      @(negedge clk);
      cs = 1'b0;
      check("inflight_valid", 32'(rd_valid), 32'd0);
      check("inflight_data",  32'(data_out), 32'h00);
      check("inflight_busy",  32'(busy), 32'd1);

      // Release, then pulse reset at sweep cycle 500: sweep restarts from zero.
      rst_n = 1'b1;
      repeat (500) @(negedge clk);
      check("mid_sweep_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      count_busy(cnt);
      check("restart_cycles", 32'(cnt), 32'd1024);
      for (int k = 0; k < 1024; k++) begin
         step(0, 1'b1, 1'b0, 10'(k), 8'h00);
         check($sformatf("reclr_valid[%0d]", k), 32'(rd_valid), 32'd1);
         check($sformatf("reclr_data[%0d]", k),  32'(data_out), 32'h00);
      end
      idle();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
